keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner that drives active-low column strobes, samples synchronised active-low row inputs, and debounces over whole scan frames. It reports one validated key code per press through a valid/ack handshake. The block sits between the keypad pins and the keypad consumer logic, and generalises the fixed 4-column free-running column counter to arbitrary matrix sizes. Over the fixed counter it adds dwell timing, debounce, ghost/multi-key rejection and overrun flagging.

## Interface
- NUM_COLS, 4, number of column strobes (≥2)
- NUM_ROWS, 4, number of row inputs (≥1)
- SCAN_DIV, 4, clock cycles each column is driven (≥4)
- DEBOUNCE_SCANS, 3, consecutive identical frames required to accept a press or release (≥1)
- Derived: CODE_W = max(1, clog2(NUM_ROWS·NUM_COLS)); IDX_W = max(1, clog2(NUM_COLS))

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- row  in  NUM_ROWS  asynchronous keypad rows, active-low (0 = pressed key in driven column)
- key_ack  in  1  consumer accepts current key_code
- col  out  NUM_COLS  column strobes, one-hot active-low
- col_idx  out  IDX_W  index of driven column
- key_code  out  CODE_W  row·NUM_COLS + column of last accepted key
- key_valid  out  1  key_code pending, held until acked
- key_held  out  1  debounced key currently down
- overrun  out  1  sticky: an accepted press was dropped while key_valid was pending

## Operation
- Reset values: col_idx=0, col=all ones except bit 0 low, dwell counter=0, key_code=0, key_valid=0, key_held=0, overrun=0, FSM=IDLE, candidate=0, debounce count=0, frame snapshot cleared, row synchroniser=all ones.
- Rows pass through a 2-flop synchroniser before any use.
- Column drive: col[c]=0 only for c=col_idx. The dwell counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps, and col_idx advances by 1, wrapping NUM_COLS-1→0.
- Sampling: on dwell cycle SCAN_DIV-1, the synchronised rows are ANDed with the active-low sense and recorded for col_idx.
- Frame end is dwell cycle SCAN_DIV-1 of column NUM_COLS-1. The frame result is evaluated there:
  - NONE: zero keys down.
  - SINGLE(k): exactly one key down, k = row·NUM_COLS + col.
  - MULTI: two or more keys down. MULTI is handled as "not the candidate" and never as a key.
- Debounce FSM, updated only at frame end:
  - IDLE: SINGLE(k) → PRESS_CHK, candidate=k, count=1; if DEBOUNCE_SCANS=1, go directly to HELD with an accept. Otherwise stay in IDLE.
  - PRESS_CHK: SINGLE(candidate) → count+1; when count reaches DEBOUNCE_SCANS → HELD with an accept. SINGLE(j≠candidate) → restart with candidate=j, count=1. NONE/MULTI → IDLE.
  - HELD: SINGLE(candidate) → stay. Anything else → RELEASE_CHK, count=1 (if DEBOUNCE_SCANS=1, → IDLE).
  - RELEASE_CHK: SINGLE(candidate) → HELD, with no new accept. Anything else → count+1; when count reaches DEBOUNCE_SCANS → IDLE.
- key_held=1 in HELD and RELEASE_CHK.
- Accept handling:
  - If key_valid=0, or key_ack=1 in the same cycle: key_code=candidate, key_valid=1.
  - Otherwise: key_code and key_valid are unchanged, and overrun is set.
- key_ack with key_valid=1 and no simultaneous accept clears key_valid and overrun. key_ack with key_valid=0 is ignored.
- rst mid-scan or mid-debounce restores all reset values on the next edge. Any pending key is discarded.

## Timing
- Frame period = NUM_COLS·SCAN_DIV cycles. Column 0 is driven during cycles 0..SCAN_DIV-1 after reset release.
- Row-to-sample path: 2 synchroniser cycles. With SCAN_DIV≥4, the sampled row reflects the column driven at least one cycle earlier.
- Press latency: key_valid rises on the edge after the frame end of the DEBOUNCE_SCANS-th consecutive SINGLE(k) frame.
- key_held rises with key_valid's accept edge. It falls on the edge after the DEBOUNCE_SCANS-th non-matching frame end.
- key_valid falls on the edge where key_ack=1 is sampled. key_code is stable whenever key_valid=1.
- All outputs are registered. No combinational path from row or key_ack to any output.

## Test plan
(Parameters NUM_COLS=4, NUM_ROWS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3; frame period 16 cycles.)
- Reset/scan: release rst, no keys → col sequence 1110,1101,1011,0111 with 4 cycles each, repeating. col_idx is 0,1,2,3. key_valid, key_held and overrun stay 0.
- Clean press: key row2/col1 held from cycle 0 → key_code=9, key_valid=1 one cycle after the third frame end (cycle 48); key_held=1 at the same edge. key_ack at cycle 60 → key_valid=0 at 61. Release → key_held=0 after 3 empty frames.
- Bounce: key 5 down for 1 frame, up for 1 frame, then down steadily → no accept until 3 consecutive matching frames; exactly one key_valid pulse train.
- Multi-key: keys 0 and 15 held together → no accept. Releasing key 15 → key_code=0 after 3 further frames.
- Overrun: accept key 3 without ack, then press key 12 → key_valid stays 1, key_code stays 3, overrun=1. key_ack clears both. An ack in the same cycle as an accept loads the new code with no overrun.
- Reset mid-debounce: assert rst after 2 matching frames of key 7 → all outputs return to reset values the next cycle, and the debounce count restarts from zero.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key code handshake between the keypad scanner and its consumer
interface keypad_scanner_if #(
    parameter int CODE_W = 4
) ();
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ack;

    modport master (output key_code, output key_valid, input key_ack);
    modport slave  (input key_code, input key_valid, output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad column scanner with frame debounce and key handshake
module keypad_scanner #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 4,
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int NUM_KEYS      = NUM_ROWS * NUM_COLS,
    localparam int CODE_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int IDX_W         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    keypad_scanner_if.master    key_if,
    output logic [NUM_COLS-1:0] col,
    output logic [IDX_W-1:0]    col_idx,
    output logic                key_held,
    output logic                overrun
);

    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] COL_LAST   = IDX_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_HELD,
        S_RELEASE_CHK
    } state_t;

    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;

    logic [DW_W-1:0]     dwell_q,   dwell_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q,     col_d;
    logic [NUM_KEYS-1:0] snap_q,    snap_d;

    state_t              state_q,   state_d;
    logic [CODE_W-1:0]   cand_q,    cand_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;

    logic [CODE_W-1:0]   code_q,    code_d;
    logic                valid_q,   valid_d;
    logic                held_q,    held_d;
    logic                overrun_q, overrun_d;

    logic                sample_en;
    logic                frame_end;
    logic [1:0]          hits;
    logic [CODE_W-1:0]   frame_key;
    logic                frame_single;
    logic                frame_match;
    logic                accept;

    // Column drive and per-column sampling of the synchronised rows
    always_comb begin
        sample_en = (dwell_q == DWELL_LAST);
        frame_end = sample_en && (col_idx_q == COL_LAST);

        dwell_d   = sample_en ? '0 : dwell_q + DW_W'(1);
        col_idx_d = col_idx_q;
        if (sample_en) begin
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + IDX_W'(1);
        end

        col_d = '1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_idx_d == IDX_W'(c)) begin
                col_d[c] = 1'b0;
            end
        end

        snap_d = snap_q;
        if (sample_en) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (col_idx_q == IDX_W'(c)) begin
                        snap_d[r*NUM_COLS + c] = ~row_sync_q[r];
                    end
                end
            end
        end
    end

    // Frame classification includes the column sampled on this very cycle
    always_comb begin
        hits      = 2'd0;
        frame_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (snap_d[k]) begin
                if (hits == 2'd0) begin
                    frame_key = CODE_W'(k);
                end
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
            end
        end
        frame_single = (hits == 2'd1);
        frame_match  = frame_single && (frame_key == cand_q);
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_key;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end else begin
                            state_d = S_PRESS_CHK;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (frame_match) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_key;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (!frame_match) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE_CHK;
                    end
                end
                S_RELEASE_CHK: begin
                    if (frame_match) begin
                        state_d = S_HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A pending code is never overwritten unless the consumer acks on the same edge
    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (accept) begin
            if (!valid_q || key_if.key_ack) begin
                code_d  = cand_d;
                valid_d = 1'b1;
                if (key_if.key_ack) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (key_if.key_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        held_d = (state_d == S_HELD) || (state_d == S_RELEASE_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            dwell_q    <= '0;
            col_idx_q  <= '0;
            col_q      <= {{(NUM_COLS-1){1'b1}}, 1'b0};
            snap_q     <= '0;
            state_q    <= S_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            snap_q     <= snap_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
            overrun_q  <= overrun_d;
        end
    end

    assign col              = col_q;
    assign col_idx          = col_idx_q;
    assign key_held         = held_q;
    assign overrun          = overrun_q;
    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a 4x4 keypad model
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [1:0]  col_idx;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int exp_q[$];

    logic ack_s;
    logic rst_s;
    logic vld_last = 1'b0;

    keypad_scanner_if #(.CODE_W(4)) key_if ();

    keypad_scanner #(
        .NUM_COLS       (4),
        .NUM_ROWS       (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .key_if   (key_if),
        .col      (col),
        .col_idx  (col_idx),
        .key_held (key_held),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Keypad: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        key_if.key_ack = 1'b0;
        pressed        = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_ack();
        key_if.key_ack = 1'b1;
        @(negedge clk);
        key_if.key_ack = 1'b0;
    endtask

    // Each new code delivery pops the oldest expected key
    always @(posedge clk) begin
        ack_s = key_if.key_ack;
        rst_s = rst;
        #1;
        if (!rst_s && key_if.key_valid && (!vld_last || ack_s)) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_key", exp_q.size(), 1);
            else                   check_eq("sb_key_code", key_if.key_code, exp_q.pop_front());
        end
        vld_last = key_if.key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0] ecol;
        key_if.key_ack = 1'b0;

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        check_eq("rst_col", col, 4'b1110);
        check_eq("rst_col_idx", col_idx, 0);
        check_eq("rst_code", key_if.key_code, 0);
        check_eq("rst_valid", key_if.key_valid, 0);
        check_eq("rst_held", key_held, 0);
        check_eq("rst_overrun", overrun, 0);

        // Free-running scan with no keys
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ecol = 4'hF;
            ecol[(k/4) % 4] = 1'b0;
            check_eq("scan_col", col, ecol);
            check_eq("scan_col_idx", col_idx, (k/4) % 4);
            @(negedge clk);
        end
        check_eq("scan_valid", key_if.key_valid, 0);
        check_eq("scan_held", key_held, 0);
        check_eq("scan_overrun", overrun, 0);

        // Clean press of key 9, ack, release
        do_reset();
        pressed = 16'(1) << 9;
        exp_q.push_back(9);
        wait_cyc(47);
        check_eq("press_valid_early", key_if.key_valid, 0);
        wait_cyc(48);
        check_eq("press_valid", key_if.key_valid, 1);
        check_eq("press_held", key_held, 1);
        wait_cyc(60);
        pulse_ack();
        check_eq("press_ack_valid", key_if.key_valid, 0);
        wait_cyc(64);
        pressed = '0;
        wait_cyc(111);
        check_eq("release_held_early", key_held, 1);
        wait_cyc(112);
        check_eq("release_held", key_held, 0);

        // Bounce on key 5
        do_reset();
        pressed = 16'(1) << 5;
        exp_q.push_back(5);
        wait_cyc(16);
        pressed = '0;
        wait_cyc(32);
        pressed = 16'(1) << 5;
        wait_cyc(79);
        check_eq("bounce_valid_early", key_if.key_valid, 0);
        wait_cyc(80);
        check_eq("bounce_valid", key_if.key_valid, 1);

        // Two keys rejected, survivor accepted after three frames
        do_reset();
        pressed = 16'h8001;
        wait_cyc(80);
        check_eq("multi_valid", key_if.key_valid, 0);
        check_eq("multi_held", key_held, 0);
        pressed = 16'h0001;
        exp_q.push_back(0);
        wait_cyc(127);
        check_eq("multi_valid_early", key_if.key_valid, 0);
        wait_cyc(128);
        check_eq("multi_valid", key_if.key_valid, 1);

        // Overrun, then an ack coinciding with an accept
        do_reset();
        pressed = 16'(1) << 3;
        exp_q.push_back(3);
        wait_cyc(48);
        check_eq("ovr_first_valid", key_if.key_valid, 1);
        pressed = 16'(1) << 12;
        wait_cyc(143);
        check_eq("ovr_flag_early", overrun, 0);
        wait_cyc(144);
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_valid_kept", key_if.key_valid, 1);
        check_eq("ovr_code_kept", key_if.key_code, 3);
        wait_cyc(150);
        pulse_ack();
        check_eq("ovr_ack_valid", key_if.key_valid, 0);
        check_eq("ovr_ack_flag", overrun, 0);
        wait_cyc(160);
        pressed = 16'(1) << 6;
        exp_q.push_back(6);
        wait_cyc(256);
        check_eq("ovr_second_valid", key_if.key_valid, 1);
        pressed = 16'(1) << 10;
        exp_q.push_back(10);
        wait_cyc(351);
        check_eq("same_cycle_pending_code", key_if.key_code, 6);
        pulse_ack();
        check_eq("same_cycle_valid", key_if.key_valid, 1);
        check_eq("same_cycle_code", key_if.key_code, 10);
        check_eq("same_cycle_overrun", overrun, 0);

        // Reset in the middle of debouncing key 7
        do_reset();
        pressed = 16'(1) << 7;
        wait_cyc(36);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_col", col, 4'b1110);
        check_eq("midrst_col_idx", col_idx, 0);
        check_eq("midrst_valid", key_if.key_valid, 0);
        check_eq("midrst_held", key_held, 0);
        check_eq("midrst_code", key_if.key_code, 0);
        rst = 1'b0;
        exp_q.push_back(7);
        wait_cyc(47);
        check_eq("midrst_valid_early", key_if.key_valid, 0);
        wait_cyc(48);
        check_eq("midrst_valid_late", key_if.key_valid, 1);
        repeat (4) @(negedge clk);

        check_eq("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
